dm_cache: RTL

// - Memory responder for the multicycle RV32I core: answers mem_read/mem_write word requests with mem_resp.
// - Direct-mapped, write-back, write-allocate cache; 32-byte lines.
// - Misses fetch the line over a 256-bit physical-memory port (pmem_*); dirty victims are written back first.

---
 rtl/cache_types.sv | 24 ++
 rtl/cache_line_array.sv | 62 ++++++
 rtl/dm_cache.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cache_types.sv
// Shared types and helpers for the direct-mapped write-back cache.
package cache_types;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} cache_state_t;

  localparam int unsigned OFFSET_BITS = 5;
  localparam int unsigned LINE_BITS   = 256;

  // Merge a byte-masked CPU word into word slot 'sel' of a line.
  function automatic logic [LINE_BITS-1:0] merge_word(input logic [LINE_BITS-1:0] line,
                                                      input logic [2:0]           sel,
                                                      input logic [31:0]          wdata,
                                                      input logic [3:0]           be);
    logic [LINE_BITS-1:0] res;
    int base;
    res  = line;
    base = int'(sel) * 32;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[base + b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage: async read, sync line/word writes, async clear of valid and dirty bits.
module cache_line_array
  import cache_types::*;
#(
  parameter int unsigned S_INDEX = 3,
  localparam int unsigned TAG_W  = 27 - S_INDEX,
  localparam int unsigned SETS   = 2 ** S_INDEX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [S_INDEX-1:0]   index,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_data,
  input  logic                 line_we,
  input  logic [TAG_W-1:0]     line_tag,
  input  logic [LINE_BITS-1:0] line_data,
  input  logic                 word_we,
  input  logic [2:0]           word_sel,
  input  logic [3:0]           word_be,
  input  logic [31:0]          word_data,
  input  logic                 clr_dirty
);

  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (line_we) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else if (word_we && (word_be != 4'b0000)) begin
        dirty_q[index] <= 1'b1;
      end else if (clr_dirty) begin
        dirty_q[index] <= 1'b0;
      end
    end
  end

  // Tag and data contents need no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[index]  <= line_tag;
      data_q[index] <= line_data;
    end else if (word_we) begin
      data_q[index] <= merge_word(data_q[index], word_sel, word_data, word_be);
    end
  end

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped write-back, write-allocate cache with 32-byte lines and a 256-bit memory port.
module dm_cache
  import cache_types::*;
#(
  parameter int unsigned S_INDEX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_address,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [3:0]           mem_byte_enable,
  input  logic [31:0]          mem_wdata,
  output logic [31:0]          mem_rdata,
  output logic                 mem_resp,
  output logic [31:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  localparam int unsigned TAG_W = 27 - S_INDEX;

  cache_state_t state_q, state_d;
  logic [26:0]  miss_line_q;

  logic                 req, hit;
  logic [S_INDEX-1:0]   arr_index;
  logic                 rd_valid, rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic                 line_we, word_we, clr_dirty;
  logic                 unused_addr;

  assign unused_addr = ^mem_address[1:0];
  assign req         = mem_read | mem_write;

  // During a miss the array is addressed by the latched line, so a dropped
  // or changed request cannot redirect the in-flight transaction.
  assign arr_index = (state_q == IDLE) ? mem_address[4+S_INDEX:5] : miss_line_q[S_INDEX-1:0];
  assign hit       = rd_valid && (rd_tag == mem_address[31:5+S_INDEX]);

  cache_line_array #(
    .S_INDEX(S_INDEX)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .index    (arr_index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .line_we  (line_we),
    .line_tag (miss_line_q[26:S_INDEX]),
    .line_data(pmem_rdata),
    .word_we  (word_we),
    .word_sel (mem_address[4:2]),
    .word_be  (mem_byte_enable),
    .word_data(mem_wdata),
    .clr_dirty(clr_dirty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_line_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req && !hit) miss_line_q <= mem_address[31:5];
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    line_we      = 1'b0;
    word_we      = 1'b0;
    clr_dirty    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            word_we  = mem_write;
            if (mem_read) mem_rdata = rd_data[{mem_address[4:2], 5'b0} +: 32];
          end else if (rd_valid && rd_dirty) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {rd_tag, miss_line_q[S_INDEX-1:0], 5'b0};
        pmem_wdata   = rd_data;
        if (pmem_resp) begin
          clr_dirty = 1'b1;
          state_d   = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_line_q, 5'b0};
        if (pmem_resp) begin
          line_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
